hellow_world_onchip_memory_bist: RTL and testbench



---
 rtl/hellow_world_onchip_memory_bist.sv | 201 ++++++++++++++++++++
 tb/tb_hellow_world_onchip_memory_bist.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hellow_world_onchip_memory_bist.sv
// rtl/hellow_world_onchip_memory_bist.sv - three-phase march self-test master for the on-chip RAM s1 port
// Writes P(a), then read-P/write-~P per word, then reads ~P back; reports the first failure and a saturating count.
module hellow_world_onchip_memory_bist #(
  parameter int          DEPTH  = 25000,
  parameter int          ADDR_W = 15,
  parameter int          DATA_W = 32,
  parameter logic [31:0] SEED   = 32'h5A5A_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       fail_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [1:0]        first_fail_phase,
  output logic [DATA_W-1:0] first_fail_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic [2:0] {IDLE, W0, R0W1_RD, R0W1_WR, R1, DRAIN, FIN} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic                cs_n, wr_n;
  logic [3:0]          be_n;
  logic [DATA_W-1:0]   wd_n;
  logic                start_ok;
  logic                cmp_valid, miscompare;
  logic [DATA_W-1:0]   cmp_expect;
  logic [ADDR_W-1:0]   cmp_addr;
  logic [1:0]          cmp_phase;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    logic [14:0] a15;
    a15 = 15'(a);
    return DATA_W'(SEED ^ {a15, 2'b00, a15});
  endfunction

  assign mem_clken = 1'b1;
  assign start_ok  = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr  <= '0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = addr;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = W0;
          addr_n  = '0;
        end
      end
      W0: begin
        if (addr == LAST) begin
          state_n = R0W1_RD;
          addr_n  = '0;
        end else begin
          addr_n = addr + ADDR_W'(1);
        end
      end
      R0W1_RD: state_n = R0W1_WR;
      R0W1_WR: begin
        if (addr == LAST) begin
          state_n = R1;
          addr_n  = '0;
        end else begin
          state_n = R0W1_RD;
          addr_n  = addr + ADDR_W'(1);
        end
      end
      R1: begin
        if (addr == LAST) state_n = DRAIN;
        else              addr_n  = addr + ADDR_W'(1);
      end
      DRAIN:   state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Bus signals are computed from the next state so the registered outputs line up with the state they belong to.
  always_comb begin
    cs_n = 1'b0;
    wr_n = 1'b0;
    be_n = 4'h0;
    wd_n = '0;
    case (state_n)
      W0: begin
        cs_n = 1'b1;
        wr_n = 1'b1;
        be_n = 4'hF;
        wd_n = pattern(addr_n);
      end
      R0W1_RD, R1: begin
        cs_n = 1'b1;
        be_n = 4'hF;
      end
      R0W1_WR: begin
        cs_n = 1'b1;
        wr_n = 1'b1;
        be_n = 4'hF;
        wd_n = ~pattern(addr_n);
      end
      default: ;
    endcase
  end

  // R1 checks the read issued one cycle earlier; the first R1 cycle has nothing outstanding.
  always_comb begin
    cmp_valid  = 1'b0;
    cmp_expect = '0;
    cmp_addr   = addr;
    cmp_phase  = 2'd0;
    case (state)
      R0W1_WR: begin
        cmp_valid  = 1'b1;
        cmp_expect = pattern(addr);
        cmp_phase  = 2'd1;
      end
      R1: begin
        cmp_valid  = (addr != '0);
        cmp_addr   = addr - ADDR_W'(1);
        cmp_expect = ~pattern(addr - ADDR_W'(1));
        cmp_phase  = 2'd2;
      end
      DRAIN: begin
        cmp_valid  = 1'b1;
        cmp_expect = ~pattern(addr);
        cmp_phase  = 2'd2;
      end
      default: ;
    endcase
  end

  assign miscompare = cmp_valid && (mem_readdata != cmp_expect);

  always_ff @(posedge clk) begin
    if (reset) begin
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      fail_count       <= '0;
      first_fail_addr  <= '0;
      first_fail_phase <= '0;
      first_fail_data  <= '0;
      mem_address      <= '0;
      mem_byteenable   <= 4'h0;
      mem_chipselect   <= 1'b0;
      mem_write        <= 1'b0;
      mem_writedata    <= '0;
    end else begin
      mem_address    <= addr_n;
      mem_byteenable <= be_n;
      mem_chipselect <= cs_n;
      mem_write      <= wr_n;
      mem_writedata  <= wd_n;
      if (start_ok) begin
        busy             <= 1'b1;
        done             <= 1'b0;
        pass             <= 1'b0;
        fail_count       <= '0;
        first_fail_addr  <= '0;
        first_fail_phase <= '0;
        first_fail_data  <= '0;
      end
      if (state == FIN) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (fail_count == 16'd0);
      end
      if (miscompare) begin
        if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
        if (fail_count == 16'd0) begin
          first_fail_addr  <= cmp_addr;
          first_fail_phase <= cmp_phase;
          first_fail_data  <= mem_readdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_hellow_world_onchip_memory_bist.sv
// tb/tb_hellow_world_onchip_memory_bist.sv - scoreboard bench with a behavioural RAM and injectable read faults
module tb_hellow_world_onchip_memory_bist;

  localparam int          DEPTH = 8;
  localparam logic [31:0] SEED  = 32'h5A5A_0000;
  localparam int          BUSY_CYCLES = 4 * DEPTH + 2;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done, pass;
  logic [15:0] fail_count;
  logic [14:0] first_fail_addr;
  logic [1:0]  first_fail_phase;
  logic [31:0] first_fail_data;
  logic [14:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;

  hellow_world_onchip_memory_bist #(
    .DEPTH(DEPTH), .ADDR_W(15), .DATA_W(32), .SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
    .first_fail_addr(first_fail_addr), .first_fail_phase(first_fail_phase),
    .first_fail_data(first_fail_data),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pass;
    logic [15:0] fc;
    logic [14:0] ffa;
    logic [1:0]  ffp;
    logic [31:0] ffd;
  } exp_t;

  exp_t exp_q[$];
  int   snap_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   fault_mode = 0;

  function automatic logic [31:0] pat(input int a);
    logic [14:0] x;
    x = a[14:0];
    return SEED ^ {x, 2'b00, x};
  endfunction

  // Behavioural s1 slave: read data registered one clock after the address.
  logic [31:0] ram [0:255];
  logic [31:0] rd_q = 32'h0;
  logic [14:0] rd_addr_q = 15'h0;
  int          read_idx = 0;
  int          rd_idx_q = 0;

  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address[7:0]][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        rd_q      <= ram[mem_address[7:0]];
        rd_addr_q <= mem_address;
        rd_idx_q  <= read_idx;
        read_idx  <= read_idx + 1;
      end
    end
    if (start && !busy) read_idx <= 0;
  end

  always_comb begin
    mem_readdata = rd_q;
    case (fault_mode)
      1: if (rd_addr_q == 15'd4 || rd_addr_q == 15'd5) mem_readdata[0] = 1'b1;
      2: if (rd_idx_q >= DEPTH) mem_readdata = rd_q ^ 32'h0000_0100;
      3: mem_readdata = rd_q ^ 32'h0000_0100;
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: completion scoreboard, reset-state snapshots and per-write bus checks.
  int   busy_cnt = 0, wait_cnt = 0, wr_cnt = 0;
  logic done_prev = 1'b0, busy_prev = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    if (busy && !busy_prev) wr_cnt = 0;
    if (busy && mem_chipselect && mem_write) begin
      int ea;
      logic [31:0] ed;
      ea = (wr_cnt < DEPTH) ? wr_cnt : wr_cnt - DEPTH;
      ed = (wr_cnt < DEPTH) ? pat(ea) : ~pat(ea);
      chk("wr_addr", 64'(mem_address), 64'(ea));
      chk("wr_data", 64'(mem_writedata), 64'(ed));
      chk("wr_be", 64'(mem_byteenable), 64'(4'hF));
      if (wr_cnt == 3) chk("w0_addr3_data", 64'(mem_writedata), 64'(32'h5A5C_0003));
      wr_cnt++;
    end
    if (busy) begin
      busy_cnt++;
    end else begin
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("pass", 64'(pass), 64'(e.pass));
          chk("fail_count", 64'(fail_count), 64'(e.fc));
          chk("first_fail_addr", 64'(first_fail_addr), 64'(e.ffa));
          chk("first_fail_phase", 64'(first_fail_phase), 64'(e.ffp));
          chk("first_fail_data", 64'(first_fail_data), 64'(e.ffd));
          chk("busy_cycles", 64'(busy_cnt), 64'(BUSY_CYCLES));
          wait_cnt = 0;
        end
      end
      busy_cnt = 0;
    end
    if (exp_q.size() != 0) begin
      wait_cnt++;
      if (wait_cnt > 500) begin
        chk("done_timeout", 64'(wait_cnt), 64'(BUSY_CYCLES));
        void'(exp_q.pop_front());
        wait_cnt = 0;
      end
    end
    if (snap_q.size() != 0) begin
      void'(snap_q.pop_front());
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_pass", 64'(pass), 64'(0));
      chk("rst_fail_count", 64'(fail_count), 64'(0));
      chk("rst_ff_addr", 64'(first_fail_addr), 64'(0));
      chk("rst_ff_phase", 64'(first_fail_phase), 64'(0));
      chk("rst_ff_data", 64'(first_fail_data), 64'(0));
      chk("rst_cs", 64'(mem_chipselect), 64'(0));
      chk("rst_wr", 64'(mem_write), 64'(0));
      chk("rst_be", 64'(mem_byteenable), 64'(0));
      chk("rst_addr", 64'(mem_address), 64'(0));
      chk("rst_wdata", 64'(mem_writedata), 64'(0));
      chk("clken", 64'(mem_clken), 64'(1));
    end
    done_prev = done;
    busy_prev = busy;
  end

  task automatic push_exp(input logic p, input logic [15:0] fc, input logic [14:0] ffa,
                          input logic [1:0] ffp, input logic [31:0] ffd);
    exp_t x;
    x.pass = p; x.fc = fc; x.ffa = ffa; x.ffp = ffp; x.ffd = ffd;
    exp_q.push_back(x);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_hang: %0d entries left, required 0", exp_q.size());
      $fatal(1, "bench stopped");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic snap_reset_state();
    @(posedge clk);
    #1 snap_q.push_back(1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    snap_reset_state();
    @(negedge clk) reset = 1'b0;
    snap_reset_state();

    // Fault-free RAM.
    push_exp(1'b1, 16'd0, 15'd0, 2'd0, 32'h0);
    pulse_start();
    wait_drained();

    // bit0 stuck-at-1 at words 4 and 5: R0W1 fails at 4 (P(4) bit0=0), R1 fails at 5 (~P(5) bit0=0).
    fault_mode = 1;
    push_exp(1'b0, 16'd2, 15'd4, 2'd1, 32'h5A52_0005);
    pulse_start();
    wait_drained();

    // Every R1 read corrupted: first failure is addr 0, ~P(0)^0x100.
    fault_mode = 2;
    push_exp(1'b0, 16'd8, 15'd0, 2'd2, 32'hA5A5_FEFF);
    pulse_start();
    wait_drained();

    // Every read corrupted with the counter preloaded near the top: count must stick at FFFF.
    fault_mode = 3;
    push_exp(1'b0, 16'hFFFF, 15'd0, 2'd0, 32'h0);
    pulse_start();
    force dut.fail_count = 16'hFFFD;
    @(negedge clk);
    release dut.fail_count;
    wait_drained();

    // Reset in the middle of R0W1, then a clean rerun.
    fault_mode = 0;
    pulse_start();
    repeat (11) @(negedge clk);
    reset = 1'b1;
    snap_reset_state();
    @(negedge clk) reset = 1'b0;
    push_exp(1'b1, 16'd0, 15'd0, 2'd0, 32'h0);
    pulse_start();
    wait_drained();

    // start while busy must not restart; the busy length check covers it.
    push_exp(1'b1, 16'd0, 15'd0, 2'd0, 32'h0);
    pulse_start();
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_drained();

    // start together with reset: reset wins and the block stays idle.
    @(negedge clk) begin
      reset = 1'b1;
      start = 1'b1;
    end
    snap_reset_state();
    @(negedge clk) begin
      reset = 1'b0;
      start = 1'b0;
    end
    repeat (3) @(negedge clk);
    snap_reset_state();
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
